// File: rtl/count_capture_pkg.sv
// Shared types for the count snapshot stage: entry layout and tag encodings.
package count_capture_pkg;

    localparam int CAP_WIDTH = 8;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_TRIG = 2'b01;
    localparam logic [1:0] TAG_WRAP = 2'b10;
    localparam logic [1:0] TAG_BOTH = 2'b11;

    typedef struct packed {
        logic wrap;
        logic trig;
    } cap_tag_t;

    typedef struct packed {
        cap_tag_t               tag;
        logic [CAP_WIDTH-1:0]   data;
    } cap_entry_t;

endpackage

// File: rtl/count_capture_if.sv
// Valid/ready snapshot stream presented by count_capture to its consumer.
interface count_capture_if
    import count_capture_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    cap_tag_t           out_tag;

    modport master (
        output out_valid,
        output out_data,
        output out_tag,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_tag,
        output out_ready
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Register-based FIFO; the head is read straight from storage, so a pushed
// entry only becomes visible on the cycle after the write.
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cap_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [LW-1:0]   level_o
);
    entry_t             mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               push_en, pop_en;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_en && !pop_en)      level_d = level_q + LW'(1);
        else if (!push_en && pop_en) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/count_capture.sv
// Snapshots the upstream counter on trigger rising edges and on wrap-around,
// queues the snapshots and reports dropped events.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        count_in,
    input  logic                    trig,
    input  logic                    clr_ovf,
    count_capture_if.master         bus,
    output logic                    ovf,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);
    typedef struct packed {
        cap_tag_t           tag;
        logic [WIDTH-1:0]   data;
    } entry_t;

    logic               trig_q;
    logic [WIDTH-1:0]   count_q;
    logic               ovf_q, ovf_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic               trig_ev, wrap_ev, event_any, pop, drop;
    logic               full, empty;
    entry_t             push_entry, head;

    assign trig_ev   = trig & ~trig_q;
    assign wrap_ev   = (count_q == '1) & (count_in == '0);
    assign event_any = trig_ev | wrap_ev;

    assign push_entry.tag.wrap = wrap_ev;
    assign push_entry.tag.trig = trig_ev;
    assign push_entry.data     = count_in;

    assign pop  = bus.out_valid & bus.out_ready;
    assign drop = event_any & full & ~pop;

    capture_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (event_any),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : head.data;
    assign bus.out_tag   = empty ? '0 : head.tag;

    // A drop in the clear cycle restarts the count at one rather than zero.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)               drop_cnt_d = DROP_W'(1);
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end else if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            trig_q     <= trig;
            count_q    <= count_in;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/count_capture.md
# count_capture

Event-driven snapshot stage that sits directly downstream of the free-running `counter` block. It watches the counter's `out` value and records a snapshot of the count in two cases: on a rising edge of an external trigger, and on every counter wrap-around (all-ones to zero). Snapshots are queued in a small FIFO and presented on a valid/ready stream. Overflow is reported through a sticky flag and a drop counter.

## Interface
- `WIDTH`, 8, width of the counter value and of the captured data.
- `DEPTH`, 4, number of FIFO entries; must be a power of two, ≥ 2.
- `DROP_W`, 8, width of the saturating drop counter.

- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `count_in`  in  WIDTH  counter value, connected to `counter.out`.
- `trig`  in  1  synchronous capture request; a snapshot is taken on its rising edge.
- `clr_ovf`  in  1  single-cycle clear for `ovf` and `drop_cnt`.
- `out_valid`  out  1  head FIFO entry is available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  WIDTH  captured count of the head entry.
- `out_tag`  out  2  cause of the head entry: bit0 = trigger, bit1 = wrap.
- `ovf`  out  1  sticky flag: at least one event was dropped.
- `drop_cnt`  out  DROP_W  number of dropped events; saturates at all-ones.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Edge detect: register `trig_q` holds last cycle's `trig`. `trig_ev = trig & ~trig_q`.
- Wrap detect: register `count_q` holds last cycle's `count_in`. `wrap_ev = (count_q == all-ones) & (count_in == 0)`.
- Event cycle: the cycle in which `trig_ev | wrap_ev` is true.
- Each event cycle writes exactly one entry: data = `count_in` of that cycle, tag = {`wrap_ev`, `trig_ev`]. Coincident events produce one entry with tag 2'b11.
- FIFO ordering is first in, first out. A pop occurs when `out_valid & out_ready`.
- Push while full and no pop in the same cycle:
  - the event is dropped;
  - `ovf` is set to 1;
  - `drop_cnt` increments by 1, holding at all-ones once saturated.
- Push while full with a pop in the same cycle: the push is accepted, `level` is unchanged, and nothing is dropped.
- Push while empty: the entry appears on the next cycle. There is no bypass.
- `clr_ovf`: `ovf` goes to 0 and `drop_cnt` goes to 0 in the next cycle. If a drop occurs in the same cycle as `clr_ovf`, the drop wins: `ovf` = 1 and `drop_cnt` = 1.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_tag` are held stable.
- When `out_valid` = 0, `out_data` and `out_tag` are driven to 0.
- Reset (asynchronous, active-low) immediately sets:
  - FIFO pointers to 0, `level` = 0, `out_valid` = 0;
  - `out_data` = 0, `out_tag` = 0;
  - `ovf` = 0, `drop_cnt` = 0;
  - `trig_q` = 0, `count_q` = 0.
- Reset mid-operation discards all queued entries.
- Because `trig_q` resets to 0, a `trig` already high at reset release produces one trigger event in the first active cycle.
- Because `count_q` resets to 0, no false wrap event occurs after reset.
- If the upstream counter is itself reset from all-ones to 0, that transition is recorded as a wrap. This is intended behaviour.

## Timing
- Latency: event in cycle N → `out_valid` = 1 and the entry on `out_data` in cycle N+1 (FIFO previously empty).
- Pop in cycle M → the next entry is presented in cycle M+1 with no bubble. If the FIFO becomes empty, `out_valid` = 0 in cycle M+1.
- `level`, `ovf` and `drop_cnt` are all registered and update one cycle after the causing event.
- Trigger events are spaced at least 2 cycles apart, because the edge detector needs `trig` to return low between events.

## Structure
- Package `count_capture_pkg` contains:
  - `cap_tag_t`: packed struct {wrap, trig};
  - `cap_entry_t`: packed struct {`cap_tag_t` tag; logic [WIDTH-1:0] data};
  - localparams for tag encodings.
- Sub-module `capture_fifo`: synchronous FIFO parameterised on `DEPTH` and entry type.
  - Provides push, pop, full, empty and level.
  - Reads from a registered head; no combinational read-during-write path.
- Top level holds: the edge and wrap detectors, the drop/overflow logic, and the output zeroing.

## Test plan
- Reset release, `count_in` counting from 0, one-cycle `trig` pulse at `count_in` = 0x05 → next cycle `out_valid` = 1, `out_data` = 0x05, `out_tag` = 2'b01; with `out_ready` = 1 the entry pops and `level` returns to 0.
- `count_in` sequence 0xFE, 0xFF, 0x00 with `trig` = 0 → a single entry `out_data` = 0x00, `out_tag` = 2'b10.
- `trig` rising edge in the same cycle that `count_in` goes from 0xFF to 0x00 → exactly one entry, 0x00, `out_tag` = 2'b11, `level` = 1.
- `out_ready` = 0, `DEPTH` = 4, six trigger edges at counts 0x10, 0x14, 0x18, 0x1C, 0x20, 0x24 → `level` = 4, `ovf` = 1, `drop_cnt` = 2; draining returns 0x10, 0x14, 0x18, 0x1C in that order.
- FIFO full, `out_ready` = 1 and a trigger edge in the same cycle → push accepted, `level` stays 4, `drop_cnt` unchanged; then `clr_ovf` pulse → `ovf` = 0 and `drop_cnt` = 0 one cycle later.
- Three entries queued, `reset` driven low mid-cycle → `out_valid` = 0, `level` = 0, `ovf` = 0 without waiting for a clock edge; after release with `trig` held high → exactly one entry is captured.
